// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  // Width of the frame length field (LEN_LO/LEN_HI) and of the word counter.
  localparam int LEN_W = 16;

  // Default frame start byte.
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. It emits a registered
// one-cycle word_valid pulse with the assembled word after each 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  // Holds bytes 0..2 of the word in progress. Byte 3 arrives directly from the input.
  logic [23:0] acc;

  // Byte slotting, word completion and the one-cycle valid pulse.
  // NOTE: reset is sampled on the clock edge (synchronous), so it appears
  // inside the clocked block and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx   <= 2'd0;
      acc        <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      // NOTE: the pulse defaults low every cycle. Only the 4th byte raises it,
      // so it can never stretch past one cycle.
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
      end else if (byte_valid) begin
        case (byte_idx)
          2'd0: acc[7:0]   <= byte_data;
          2'd1: acc[15:8]  <= byte_data;
          2'd2: acc[23:16] <= byte_data;
          2'd3: begin
            word       <= {byte_data, acc};
            word_valid <= 1'b1;
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader. It writes 32-bit words into instruction
// memory and holds the core in reset until a frame with a good checksum arrives.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [LEN_W-1:0]  words_loaded
);

  // Largest legal frame length is the full memory capacity.
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_W;

  loader_state_t    state;
  logic [LEN_W-1:0] len;
  logic [7:0]       sum;

  logic             accept;
  logic             restart;
  logic             data_byte;
  logic [LEN_W-1:0] len_full;
  logic [7:0]       sum_next;
  logic [1:0]       byte_idx;

  assign accept    = rx_valid && rx_ready;
  assign restart   = accept && (rx_data == MAGIC) &&
                     ((state == IDLE) || (state == DONE) || (state == ERR));
  assign data_byte = accept && (state == DATA);
  assign len_full  = {rx_data, len[7:0]};
  assign sum_next  = sum + rx_data;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // Frame-parsing FSM. It owns the length, checksum, word counter and write address.
  // NOTE: all state here uses non-blocking assignments, so every branch reads
  // the pre-edge values of len, sum and words_loaded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      sum          <= 8'd0;
      imem_addr    <= '0;
    end else begin
      rx_ready <= 1'b1;
      if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == MAGIC) begin
              state        <= LEN0;
              core_rst     <= 1'b1;
              load_done    <= 1'b0;
              load_err     <= 1'b0;
              words_loaded <= '0;
              sum          <= 8'd0;
            end
          end
          LEN0: begin
            len[7:0] <= rx_data;
            sum      <= sum_next;
            state    <= LEN1;
          end
          LEN1: begin
            len <= len_full;
            sum <= sum_next;
            if ({1'b0, len_full} > MAX_LEN) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else if (len_full == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            sum <= sum_next;
            if (byte_idx == 2'd3) begin
              imem_addr    <= ADDR_W'(words_loaded);
              words_loaded <= words_loaded + 1'b1;
              if (words_loaded + 1'b1 == len) state <= CSUM;
            end
          end
          CSUM: begin
            sum <= sum_next;
            if (sum_next == 8'd0) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_rst  <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (built with ADDR_W=4 so that the oversize
// and full-capacity frames stay short).
module tb_imem_loader;
  import loader_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_err;
  logic [15:0]   words_loaded;

  imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  tx[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. Presents one byte and returns at the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(tx[i]);
  endtask

  task automatic frame_begin(input logic [15:0] len);
    tx.delete();
    tx.push_back(8'hA5);
    tx.push_back(len[7:0]);
    tx.push_back(len[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    tx.push_back(w[7:0]);
    tx.push_back(w[15:8]);
    tx.push_back(w[23:16]);
    tx.push_back(w[31:24]);
  endtask

  // Appends the checksum, offset by 'corrupt' to force a bad frame.
  task automatic frame_end(input logic [7:0] corrupt);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 1; i < tx.size(); i++) s = s + tx[i];
    tx.push_back((8'h00 - s) + corrupt);
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rx_ready"},     32'(rx_ready),     32'd0);
    check({pfx, "_imem_we"},      32'(imem_we),      32'd0);
    check({pfx, "_imem_addr"},    32'(imem_addr),    32'd0);
    check({pfx, "_imem_wdata"},   imem_wdata,        32'd0);
    check({pfx, "_core_rst"},     32'(core_rst),     32'd1);
    check({pfx, "_load_done"},    32'(load_done),    32'd0);
    check({pfx, "_load_err"},     32'(load_err),     32'd0);
    check({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
    check({pfx, "_state"},        32'(dut.state),    32'(IDLE));
  endtask

  task automatic check_two_word_frame(input string pfx);
    check({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({pfx, "_a0"}, wr_addr[0], 32'd0);
      check({pfx, "_d0"}, wr_data[0], 32'h0010_0013);
      check({pfx, "_a1"}, wr_addr[1], 32'd1);
      check({pfx, "_d1"}, wr_data[1], 32'h0020_0093);
    end
  endtask

  initial begin
    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rx_ready_up", 32'(rx_ready), 32'd1);

    // Garbage in IDLE, then a good two-word frame with cycle-level checks.
    clear_writes();
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_state", 32'(dut.state), 32'(IDLE));
    frame_begin(16'd2);
    push_word(32'h0010_0013);
    push_word(32'h0020_0093);
    frame_end(8'd0);
    send_range(0, 6);                 // through the 4th byte of word 0
    check("lat_we",    32'(imem_we),    32'd1);
    check("lat_addr",  32'(imem_addr),  32'd0);
    check("lat_wdata", imem_wdata,      32'h0010_0013);
    check("lat_wl",    32'(words_loaded), 32'd1);
    send_byte(tx[7]);
    check("we_one_cycle", 32'(imem_we), 32'd0);
    send_range(8, 10);
    check("rst_before_csum", 32'(core_rst), 32'd1);
    send_byte(tx[11]);
    check("good_core_rst",  32'(core_rst),     32'd0);
    check("good_load_done", 32'(load_done),    32'd1);
    check("good_load_err",  32'(load_err),     32'd0);
    check("good_words",     32'(words_loaded), 32'd2);
    @(negedge clk);
    check_two_word_frame("good");

    // MAGIC after DONE re-arms the loader, then a one-word frame loads.
    clear_writes();
    frame_begin(16'd1);
    push_word(32'hDEAD_BEEF);
    frame_end(8'd0);
    send_byte(tx[0]);
    check("rearm_core_rst",  32'(core_rst),     32'd1);
    check("rearm_load_done", 32'(load_done),    32'd0);
    check("rearm_words",     32'(words_loaded), 32'd0);
    send_range(1, tx.size() - 1);
    @(negedge clk);
    check("reload_done", 32'(load_done),      32'd1);
    check("reload_rst",  32'(core_rst),       32'd0);
    check("reload_nwr",  32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("reload_a0", wr_addr[0], 32'd0);
      check("reload_d0", wr_data[0], 32'hDEAD_BEEF);
    end

    // Bad checksum: the words are still written, but the core stays in reset.
    clear_writes();
    frame_begin(16'd2);
    push_word(32'h0010_0013);
    push_word(32'h0020_0093);
    frame_end(8'd1);
    send_range(0, tx.size() - 1);
    @(negedge clk);
    check("bad_load_err",  32'(load_err),  32'd1);
    check("bad_load_done", 32'(load_done), 32'd0);
    check("bad_core_rst",  32'(core_rst),  32'd1);
    check_two_word_frame("bad");

    // Zero length frame.
    clear_writes();
    frame_begin(16'd0);
    frame_end(8'd0);
    send_range(0, tx.size() - 1);
    @(negedge clk);
    check("zero_nwr",       32'(wr_addr.size()), 32'd0);
    check("zero_load_done", 32'(load_done),      32'd1);
    check("zero_core_rst",  32'(core_rst),       32'd0);
    check("zero_words",     32'(words_loaded),   32'd0);

    // Oversize (17 > 16): error right after LEN_HI, no writes.
    clear_writes();
    frame_begin(16'd17);
    send_range(0, 2);
    check("over_load_err",  32'(load_err),  32'd1);
    check("over_core_rst",  32'(core_rst),  32'd1);
    check("over_load_done", 32'(load_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("over_nwr", 32'(wr_addr.size()), 32'd0);

    // Full capacity frame, LEN=16: fills addresses 0..15 with one write every 4 cycles.
    clear_writes();
    frame_begin(16'd16);
    for (int i = 0; i < 16; i++)
      push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    frame_end(8'd0);
    send_range(0, tx.size() - 1);
    @(negedge clk);
    check("full_load_done", 32'(load_done),      32'd1);
    check("full_core_rst",  32'(core_rst),       32'd0);
    check("full_words",     32'(words_loaded),   32'd16);
    check("full_nwr",       32'(wr_addr.size()), 32'd16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("full_a%0d", i), wr_addr[i], 32'(i));
        check($sformatf("full_d%0d", i), wr_data[i],
              {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        if (i > 0) check($sformatf("full_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
      end
    end

    // Reset after 6 bytes of a frame, then a complete frame.
    clear_writes();
    frame_begin(16'd2);
    push_word(32'h0010_0013);
    push_word(32'h0020_0093);
    frame_end(8'd0);
    send_range(0, 5);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_writes();
    send_range(0, tx.size() - 1);
    @(negedge clk);
    check("after_rst_done", 32'(load_done), 32'd1);
    check("after_rst_rst",  32'(core_rst),  32'd0);
    check_two_word_frame("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the mini-rv core. It accepts a framed byte stream from a UART receiver or debug bridge and assembles the bytes into 32-bit little-endian words. Each word is written into instruction memory through a dedicated write port. While loading, the block holds the core in reset and releases it only after a frame has been received with a valid checksum. This replaces testbench backdoor `$readmemh` loading with a synthesizable path.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock
- reset  in  1  reset: synchronous, active-low
- rx_valid  in  1  byte available
- rx_data  in  8  byte value
- rx_ready  out  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready on a rising edge
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  word data
- core_rst  out  1  active-high reset to core_top
- load_done  out  1  last frame loaded successfully (level)
- load_err  out  1  last frame failed (level)
- words_loaded  out  16  words written in the current or last frame

## Operation
- Frame format: MAGIC, LEN_LO, LEN_HI, LEN words of 4 bytes each (LSB first), CSUM.
- Checksum rule: the 8-bit sum of LEN_LO, LEN_HI, all data bytes and CSUM must equal 8'h00.
- FSM states and transitions:
  - IDLE: waits for MAGIC. Any other byte is consumed and ignored.
  - LEN0: captures LEN_LO.
  - LEN1: captures LEN_HI.
  - DATA: packs bytes into words.
  - CSUM: checks the checksum.
  - DONE: terminal state after a good frame.
  - ERR: terminal state after a bad frame.
- Accepting MAGIC in IDLE, DONE or ERR moves to LEN0, sets core_rst=1, clears load_done, load_err and words_loaded, and zeroes the running sum.
- In DONE or ERR, non-MAGIC bytes are consumed and ignored.
- In LEN1: LEN > 2^ADDR_W goes to ERR immediately. LEN == 0 goes straight to CSUM.
- In DATA: a byte index (0..3) shifts bytes into the word. On the 4th byte, the write is issued and words_loaded increments. After the LEN-th word, the FSM goes to CSUM.
- In CSUM: a sum of 0 goes to DONE with load_done=1 and core_rst=0. Any other sum goes to ERR with load_err=1 and core_rst held at 1.
- Words already written before an error remain in memory. The core never runs after a failed frame.
- Arithmetic: the running sum is 8-bit and wraps modulo 256. The word address equals the word count, truncated to ADDR_W.

## Timing
- Reset values of all outputs:
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_rst=1, load_done=0, load_err=0, words_loaded=0
  - FSM in IDLE
- rx_ready=1 in every state from the first cycle after reset deasserts. There is no backpressure; one byte can be accepted per cycle.
- Write latency: the cycle after the 4th byte of a word is accepted, imem_we=1 for exactly one cycle, with imem_addr and imem_wdata stable in that cycle. All write outputs are registered.
- Back-to-back words at one byte per cycle give one write every 4 cycles. No write overlaps another.
- core_rst deasserts the cycle after the CSUM byte is accepted with a valid sum. It reasserts the cycle after any MAGIC is accepted in DONE or ERR.
- Asserting reset mid-frame aborts the frame and restores all reset values. Partial memory contents are not cleared.

## Structure
- Package `loader_pkg` holds:
  - `loader_state_t` enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR)
  - `LOADER_MAGIC` constant
  - frame-length width constant (16)
- Sub-module `word_assembler` is natural: a byte-to-32-bit packer with byte index, clear input and word_valid output.
- The top-level FSM owns the length, sum and address counters.

## Test plan
- Good frame: A5 02 00 13 00 10 00 93 00 20 00 + correct CSUM → writes 0x00100013@0 and 0x00200093@1, load_done=1, core_rst falls, words_loaded=2.
- Bad checksum: same frame with the last byte +1 → both words are written, load_err=1, core_rst stays 1, load_done=0.
- Zero length: A5 00 00 00 → no imem_we, load_done=1, core_rst=0.
- Oversize: with ADDR_W=4, A5 11 00 → load_err=1 after LEN_HI and no writes. A following valid frame with LEN=16 loads addresses 0..15 and completes with load_done=1.
- Garbage then reload: stray bytes 00 FF are ignored in IDLE. After a completed good frame, sending A5 reasserts core_rst=1 next cycle and clears load_done; a second frame then loads and releases the core.
- Reset mid-DATA after 6 bytes → all outputs return to reset values, FSM is in IDLE, and the next full frame loads correctly.
